// File: rtl/pulse_cdc_pkg.sv
// Shared definitions for the pulse clock-domain-crossing blocks.
package pulse_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } spacerState_e;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int unsigned cntMax(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_spacer.sv
// Re-emits incoming event pulses one at a time, at least MIN_GAP idle cycles
// apart, so a slower destination clock can sample every synchronizer toggle.
module pulse_spacer
  import pulse_cdc_pkg::*;
#(
  parameter int MIN_GAP = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_i,
  input  logic             clr_ovf_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int                GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ZERO = GAP_W'(0);
  localparam int unsigned       MAX_U    = cntMax(CNT_W);
  localparam logic [CNT_W-1:0]  PEND_MAX = MAX_U[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  PEND_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PEND_0   = CNT_W'(0);

  if (MIN_GAP < 1) begin : gMinGapCheck
    $error("pulse_spacer: MIN_GAP must be at least 1");
  end

  spacerState_e     state_r;
  spacerState_e     nextState_s;
  logic [GAP_W-1:0] gapCnt_r;
  logic [GAP_W-1:0] nextGapCnt_s;
  logic [CNT_W-1:0] nextPending_s;
  logic             nextOverflow_s;
  logic             isEmit_s;
  logic             gapDone_s;
  logic             wantEmit_s;
  logic             dropEvt_s;

  // Next-state, pending counter, gap timer and overflow decisions.
  always_comb begin
    isEmit_s       = (state_r == EMIT);
    gapDone_s      = (state_r == GAP) && (gapCnt_r == GAP_ONE);
    wantEmit_s     = pulse_i || (pending_o != PEND_0);
    dropEvt_s      = pulse_i && !isEmit_s && (pending_o == PEND_MAX);
    nextState_s    = state_r;
    nextGapCnt_s   = gapCnt_r;
    nextPending_s  = pending_o;
    nextOverflow_s = overflow_o;

    case (state_r)
      IDLE: begin
        if (wantEmit_s) nextState_s = EMIT;
        else            nextState_s = IDLE;
      end
      EMIT: nextState_s = GAP;
      GAP: begin
        if (gapDone_s && wantEmit_s) nextState_s = EMIT;
        else if (gapDone_s)          nextState_s = IDLE;
        else                         nextState_s = GAP;
      end
      default: nextState_s = IDLE;
    endcase

    // An emit cycle frees a slot, so a coincident event is absorbed even when full.
    if (pulse_i && !isEmit_s && (pending_o != PEND_MAX)) nextPending_s = pending_o + PEND_ONE;
    else if (isEmit_s && !pulse_i)                      nextPending_s = pending_o - PEND_ONE;
    else                                                nextPending_s = pending_o;

    if (isEmit_s)                                       nextGapCnt_s = GAP_LOAD;
    else if ((state_r == GAP) && (gapCnt_r != GAP_ZERO)) nextGapCnt_s = gapCnt_r - GAP_ONE;
    else                                                nextGapCnt_s = gapCnt_r;

    if (dropEvt_s)      nextOverflow_s = 1'b1;
    else if (clr_ovf_i) nextOverflow_s = 1'b0;
    else                nextOverflow_s = overflow_o;
  end

  // State and registered outputs; reset discards any pending events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gapCnt_r   <= GAP_ZERO;
      pending_o  <= PEND_0;
      overflow_o <= 1'b0;
      pulse_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      gapCnt_r   <= nextGapCnt_s;
      pending_o  <= nextPending_s;
      overflow_o <= nextOverflow_s;
      pulse_o    <= (nextState_s == EMIT);
      busy_o     <= (nextState_s != IDLE) || (nextPending_s != PEND_0);
    end
  end

endmodule

// File: tb/tb_pulse_spacer.sv
// Drives three pulse_spacer configurations in parallel and compares every
// output each cycle against an event-level reference model.
module tb_pulse_spacer;

  localparam int NCFG = 3;
  localparam int MG   [NCFG] = '{4, 4, 1};
  localparam int CMAX [NCFG] = '{15, 3, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_i = 1'b0;
  logic clr_ovf_i = 1'b0;

  logic       pulse0, ovf0, busy0;
  logic [3:0] pend0;
  logic       pulse1, ovf1, busy1;
  logic [1:0] pend1;
  logic       pulse2, ovf2, busy2;
  logic [1:0] pend2;

  int nTests = 0;
  int nFail = 0;
  int cyc = 0;
  int phaseBase = 0;

  // Model state: pending events, sticky flag, cycle of the latest emission.
  int mPend [NCFG];
  int mOvf  [NCFG];
  int mLast [NCFG];

  int hP0 [64];
  int hN0 [64];
  int hB0 [64];
  int hP1 [64];
  int hN1 [64];
  int hO1 [64];

  pulse_spacer #(.MIN_GAP(4), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_i), .clr_ovf_i(clr_ovf_i),
    .pulse_o(pulse0), .pending_o(pend0), .overflow_o(ovf0), .busy_o(busy0)
  );
  pulse_spacer #(.MIN_GAP(4), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_i), .clr_ovf_i(clr_ovf_i),
    .pulse_o(pulse1), .pending_o(pend1), .overflow_o(ovf1), .busy_o(busy1)
  );
  pulse_spacer #(.MIN_GAP(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_i), .clr_ovf_i(clr_ovf_i),
    .pulse_o(pulse2), .pending_o(pend2), .overflow_o(ovf2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nTests++;
    if (obs != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCFG; i++) begin
      mPend[i] = 0;
      mOvf[i]  = 0;
      mLast[i] = -1000;
    end
  endtask

  task automatic checkAll();
    int oP [NCFG];
    int oN [NCFG];
    int oO [NCFG];
    int oB [NCFG];
    int expBusy;
    oP = '{int'(pulse0), int'(pulse1), int'(pulse2)};
    oN = '{int'(pend0), int'(pend1), int'(pend2)};
    oO = '{int'(ovf0), int'(ovf1), int'(ovf2)};
    oB = '{int'(busy0), int'(busy1), int'(busy2)};
    for (int i = 0; i < NCFG; i++) begin
      expBusy = ((mPend[i] != 0) || (cyc >= mLast[i] && cyc - mLast[i] <= MG[i])) ? 1 : 0;
      checkVal($sformatf("cfg%0d pulse_o", i), oP[i], (mLast[i] == cyc) ? 1 : 0);
      checkVal($sformatf("cfg%0d pending_o", i), oN[i], mPend[i]);
      checkVal($sformatf("cfg%0d overflow_o", i), oO[i], mOvf[i]);
      checkVal($sformatf("cfg%0d busy_o", i), oB[i], expBusy);
    end
  endtask

  // Moves the model from the current cycle to the next given this cycle's inputs.
  task automatic advance(input logic p, input logic c);
    bit emit, full, drop, avail, allowed;
    for (int i = 0; i < NCFG; i++) begin
      emit    = (mLast[i] == cyc);
      full    = (mPend[i] == CMAX[i]);
      drop    = p && !emit && full;
      avail   = (mPend[i] > 0) || p;
      allowed = (cyc >= mLast[i] + MG[i]);
      if (p && (emit || !full)) mPend[i]++;
      if (emit) mPend[i]--;
      if (drop) mOvf[i] = 1;
      else if (c) mOvf[i] = 0;
      if (avail && allowed) mLast[i] = cyc + 1;
    end
  endtask

  task automatic step(input logic p, input logic c);
    int rel;
    @(posedge clk);
    #1;
    cyc++;
    checkAll();
    rel = cyc - phaseBase;
    if (rel >= 0 && rel < 64) begin
      hP0[rel] = int'(pulse0);
      hN0[rel] = int'(pend0);
      hB0[rel] = int'(busy0);
      hP1[rel] = int'(pulse1);
      hN1[rel] = int'(pend1);
      hO1[rel] = int'(ovf1);
    end
    pulse_i   = p;
    clr_ovf_i = c;
    advance(p, c);
  endtask

  task automatic doReset();
    int seen;
    seen = 0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("async reset pulse0", int'(pulse0), 0);
    checkVal("async reset busy0", int'(busy0), 0);
    checkAll();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0);
      seen += int'(pulse0) + int'(pulse1) + int'(pulse2);
    end
    checkVal("post-reset pulses", seen, 0);
  endtask

  task automatic runPhase(input int pFrom, input int pTo, input int c1, input int c2,
                          input int len, input int rstAt);
    phaseBase = cyc + 1;
    for (int r = 0; r < len; r++) begin
      step((r >= pFrom && r <= pTo), (r == c1 || r == c2));
      if (r == rstAt) doReset();
    end
  endtask

  initial begin
    int cnt;
    int rates [5] = '{5, 30, 60, 95, 100};
    int rate;
    modelReset();
    #1;
    checkAll();
    #1 rst_n = 1'b1;

    // Single event.
    runPhase(10, 10, -1, -1, 45, -1);
    cnt = 0;
    for (int k = 0; k < 45; k++) cnt += hP0[k];
    checkVal("single pulse count", cnt, 1);
    checkVal("single pulse@11", hP0[11], 1);
    checkVal("single pending@11", hN0[11], 1);
    checkVal("single pending@12", hN0[12], 0);
    checkVal("single busy@10", hB0[10], 0);
    checkVal("single busy@15", hB0[15], 1);
    checkVal("single busy@16", hB0[16], 0);

    // Burst of three.
    runPhase(10, 12, -1, -1, 45, -1);
    cnt = 0;
    for (int k = 0; k < 45; k++) cnt += hP0[k];
    checkVal("burst pulse count", cnt, 3);
    checkVal("burst pulse@16", hP0[16], 1);
    checkVal("burst pulse@21", hP0[21], 1);
    checkVal("burst pending@13", hN0[13], 2);
    checkVal("burst pending@17", hN0[17], 1);
    checkVal("burst pending@22", hN0[22], 0);

    // Saturation, clear coincident with a drop, later plain clear.
    runPhase(10, 17, 17, 40, 46, -1);
    cnt = 0;
    for (int k = 0; k < 46; k++) cnt += hP1[k];
    checkVal("sat pulse count", cnt, 5);
    checkVal("sat pulse@31", hP1[31], 1);
    checkVal("sat overflow@14", hO1[14], 0);
    checkVal("sat overflow@15", hO1[15], 1);
    checkVal("sat pending@17", hN1[17], 3);
    checkVal("clr vs drop overflow@18", hO1[18], 1);
    checkVal("sat pending@32", hN1[32], 0);
    checkVal("clr overflow@41", hO1[41], 0);

    // Asynchronous reset in the middle of a gap with two events pending.
    runPhase(10, 12, -1, -1, 20, 14);
    checkVal("pre-reset pending0", hN0[14], 2);

    // Randomised traffic; the first segment is continuous.
    for (int seg = 0; seg < 15; seg++) begin
      rate = (seg == 0) ? 100 : rates[$urandom_range(0, 4)];
      for (int k = 0; k < 100; k++)
        step(($urandom_range(0, 99) < rate), ($urandom_range(0, 99) < 3));
    end
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
